// File: rtl/jtpang_eeprom_pkg.sv
// jtpang_eeprom_pkg
//   Shared definitions for the Pang!/SPANG 93C46-type serial EEPROM model:
//   serial opcodes, extended sub-codes (carried in the two address MSBs),
//   serial engine state encoding and pending program-op encoding.
package jtpang_eeprom_pkg;

    // Opcode: the two bits following the start bit
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_ERASE = 2'b11;
    localparam logic [1:0] OP_EXT   = 2'b00;

    // Extended sub-codes: address bits [AW-1:AW-2] when opcode is OP_EXT
    localparam logic [1:0] EXT_EWEN = 2'b11;
    localparam logic [1:0] EXT_EWDS = 2'b00;
    localparam logic [1:0] EXT_ERAL = 2'b10;
    localparam logic [1:0] EXT_WRAL = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_RD,
        ST_WR,
        ST_DONE
    } state_t;

    // Program operation waiting for the cs falling edge
    typedef enum logic [2:0] {
        PEND_NONE,
        PEND_WRITE,
        PEND_ERASE,
        PEND_ERAL,
        PEND_WRAL
    } pend_t;

endpackage

// File: rtl/jtpang_eeprom_mem.sv
// jtpang_eeprom_mem
//   64x16 true dual-port storage, no reset (contents survive rst).
//   Port A (word): addr_a/we_a/din_a, dout_a registered (1 clk).
//   Port B (byte): addr_b[AW:1] word, addr_b[0]=1 selects the MSB lane;
//                  we_b/din_b, dout_b registered (1 clk).
//   Same-word same-clk writes on both ports: port B wins.
module jtpang_eeprom_mem #(
    parameter int unsigned AW = 6,
    parameter int unsigned DW = 16
) (
    input  logic          clk,
    input  logic [AW-1:0] addr_a,
    input  logic          we_a,
    input  logic [DW-1:0] din_a,
    output logic [DW-1:0] dout_a,
    input  logic [AW:0]   addr_b,
    input  logic          we_b,
    input  logic [7:0]    din_b,
    output logic [7:0]    dout_b
);
    import jtpang_eeprom_pkg::*;

    logic [DW-1:0] mem_q [2**AW];

    always_ff @(posedge clk) begin
        if (we_a) mem_q[addr_a] <= din_a;
        // Port B assignment comes last so it overrides a port A write to the same word
        if (we_b) begin
            if (addr_b[0]) mem_q[addr_b[AW:1]][15:8] <= din_b;
            else           mem_q[addr_b[AW:1]][7:0]  <= din_b;
        end
        dout_a <= mem_q[addr_a];
        dout_b <= addr_b[0] ? mem_q[addr_b[AW:1]][15:8] : mem_q[addr_b[AW:1]][7:0];
    end

endmodule

// File: rtl/jtpang_eeprom.sv
// jtpang_eeprom
//   Device side of the 93C46-type serial EEPROM (64 x 16) used by Pang!/SPANG.
//   Ports:
//     rst (async, active-high), clk
//     cs, sclk, sdi  : CPU bit-banged serial lines (already clk-domain latches)
//     sdo            : serial data out / ready-busy status
//     dump_addr/din/we/dout : byte access for NVRAM dump/restore, 1 clk read latency
//   Optional: define JTPANG_EEPROM_BUSY_EN to hold busy for BUSY_CYCLES clk after
//   each committed program op (sdo=0 while polled, start bits ignored).
module jtpang_eeprom #(
    parameter int unsigned AW          = 6,
    parameter int unsigned DW          = 16,
    parameter int unsigned BUSY_CYCLES = 4096
) (
    input  logic        rst,
    input  logic        clk,
    input  logic        cs,
    input  logic        sclk,
    input  logic        sdi,
    output logic        sdo,
    input  logic [AW:0] dump_addr,
    input  logic [7:0]  dump_din,
    input  logic        dump_we,
    output logic [7:0]  dump_dout
);
    import jtpang_eeprom_pkg::*;

    localparam int unsigned BUSY_W = $clog2(BUSY_CYCLES + 1);
    localparam logic [4:0]  CMD_LAST  = 5'(AW + 1);
    localparam logic [4:0]  DATA_LAST = 5'(DW - 1);

    state_t        state_q, state_d;
    pend_t         pend_q, pend_d;
    logic [4:0]    cnt_q, cnt_d;
    logic [AW:0]   cmd_q, cmd_d;
    logic [DW-1:0] data_q, data_d;
    logic [DW-1:0] rd_q, rd_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          sdo_q, sdo_d;
    logic          wen_q, wen_d;
    logic          load_q, load_d;
    logic          sclk_l_q, cs_l_q;
    logic          fill_q, fill_d;
    logic [AW-1:0] fill_addr_q, fill_addr_d;
    logic [DW-1:0] fill_data_q, fill_data_d;
    logic [BUSY_W-1:0] busy_cnt_q, busy_cnt_d;

    logic          busy, commit, sclk_rise;
    logic [AW+1:0] word;
    logic [AW-1:0] addr_a;
    logic          we_a;
    logic [DW-1:0] din_a, dout_a;

    assign busy      = |busy_cnt_q;
    assign sclk_rise = sclk & ~sclk_l_q;
    assign word      = {cmd_q, sdi};
    assign sdo       = sdo_q;

    jtpang_eeprom_mem #(.AW(AW), .DW(DW)) u_mem (
        .clk    (clk),
        .addr_a (addr_a),
        .we_a   (we_a),
        .din_a  (din_a),
        .dout_a (dout_a),
        .addr_b (dump_addr),
        .we_b   (dump_we),
        .din_b  (dump_din),
        .dout_b (dump_dout)
    );

    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        cnt_d       = cnt_q;
        cmd_d       = cmd_q;
        data_d      = data_q;
        rd_d        = rd_q;
        addr_d      = addr_q;
        sdo_d       = sdo_q;
        wen_d       = wen_q;
        load_d      = 1'b0;
        fill_d      = fill_q;
        fill_addr_d = fill_addr_q;
        fill_data_d = fill_data_q;
        addr_a      = addr_q;
        we_a        = 1'b0;
        din_a       = data_q;
        commit      = !cs && cs_l_q && state_q == ST_DONE && wen_q && pend_q != PEND_NONE;

        if (!cs) begin
            state_d = ST_IDLE;
            pend_d  = PEND_NONE;
            cnt_d   = '0;
            sdo_d   = ~busy;
            if (commit) begin
                case (pend_q)
                    PEND_WRITE: we_a = 1'b1;
                    PEND_ERASE: begin we_a = 1'b1; din_a = '1; end
                    PEND_ERAL:  begin fill_d = 1'b1; fill_addr_d = '0; fill_data_d = '1; end
                    PEND_WRAL:  begin fill_d = 1'b1; fill_addr_d = '0; fill_data_d = data_q; end
                    default: ;
                endcase
            end
        end else begin
            if (state_q == ST_IDLE) sdo_d = ~busy;
            if (sclk_rise) begin
                case (state_q)
                    ST_IDLE: begin
                        // start bit; held off while busy or while the fill sequencer runs
                        if (sdi && !busy && !fill_q) begin
                            state_d = ST_CMD;
                            cnt_d   = '0;
                        end
                    end
                    ST_CMD: begin
                        cmd_d = word[AW:0];
                        cnt_d = cnt_q + 5'd1;
                        if (cnt_q == CMD_LAST) begin
                            addr_d = word[AW-1:0];
                            cnt_d  = '0;
                            case (word[AW+1:AW])
                                OP_READ: begin
                                    state_d = ST_RD;
                                    sdo_d   = 1'b0;
                                    // fetch straight from the decoded address so the
                                    // word is loaded before the first data edge
                                    addr_a  = word[AW-1:0];
                                    load_d  = 1'b1;
                                end
                                OP_WRITE: begin state_d = ST_WR;   pend_d = PEND_WRITE; end
                                OP_ERASE: begin state_d = ST_DONE; pend_d = PEND_ERASE; end
                                default: begin
                                    case (word[AW-1:AW-2])
                                        EXT_EWEN: begin state_d = ST_DONE; wen_d = 1'b1; end
                                        EXT_EWDS: begin state_d = ST_DONE; wen_d = 1'b0; end
                                        EXT_ERAL: begin state_d = ST_DONE; pend_d = PEND_ERAL; end
                                        default:  begin state_d = ST_WR;   pend_d = PEND_WRAL; end
                                    endcase
                                end
                            endcase
                        end
                    end
                    ST_RD: begin
                        sdo_d = rd_q[DW-1];
                        rd_d  = {rd_q[DW-2:0], 1'b0};
                        cnt_d = cnt_q + 5'd1;
                        if (cnt_q == DATA_LAST) begin
                            cnt_d  = '0;
                            addr_d = addr_q + AW'(1);
                            addr_a = addr_q + AW'(1);
                            load_d = 1'b1;
                        end
                    end
                    ST_WR: begin
                        data_d = {data_q[DW-2:0], sdi};
                        cnt_d  = cnt_q + 5'd1;
                        if (cnt_q == DATA_LAST) state_d = ST_DONE;
                    end
                    default: ;
                endcase
            end
        end

        if (load_q) rd_d = dout_a;

        if (fill_q) begin
            we_a        = 1'b1;
            addr_a      = fill_addr_q;
            din_a       = fill_data_q;
            fill_addr_d = fill_addr_q + AW'(1);
            if (fill_addr_q == '1) fill_d = 1'b0;
        end

`ifdef JTPANG_EEPROM_BUSY_EN
        busy_cnt_d = busy ? busy_cnt_q - BUSY_W'(1) : '0;
        if (commit) busy_cnt_d = BUSY_W'(BUSY_CYCLES);
`else
        busy_cnt_d = '0;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            pend_q      <= PEND_NONE;
            cnt_q       <= '0;
            cmd_q       <= '0;
            data_q      <= '0;
            rd_q        <= '0;
            addr_q      <= '0;
            sdo_q       <= 1'b1;
            wen_q       <= 1'b0;
            load_q      <= 1'b0;
            sclk_l_q    <= 1'b0;
            cs_l_q      <= 1'b0;
            fill_q      <= 1'b0;
            fill_addr_q <= '0;
            fill_data_q <= '0;
            busy_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            cnt_q       <= cnt_d;
            cmd_q       <= cmd_d;
            data_q      <= data_d;
            rd_q        <= rd_d;
            addr_q      <= addr_d;
            sdo_q       <= sdo_d;
            wen_q       <= wen_d;
            load_q      <= load_d;
            sclk_l_q    <= sclk;
            cs_l_q      <= cs;
            fill_q      <= fill_d;
            fill_addr_q <= fill_addr_d;
            fill_data_q <= fill_data_d;
            busy_cnt_q  <= busy_cnt_d;
        end
    end

endmodule

// File: tb/tb_jtpang_eeprom.sv
// tb_jtpang_eeprom
//   Directed bench for jtpang_eeprom: serial protocol, fills, address wrap,
//   aborted writes, dump port access and ready/busy status.
//   Honours JTPANG_EEPROM_BUSY_EN if the design is built with it.
module tb_jtpang_eeprom;

    logic       rst = 1'b1;
    logic       clk = 1'b0;
    logic       cs = 1'b0, sclk = 1'b0, sdi = 1'b0;
    logic       sdo;
    logic [6:0] dump_addr = '0;
    logic [7:0] dump_din = '0;
    logic       dump_we = 1'b0;
    logic [7:0] dump_dout;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    jtpang_eeprom #(.AW(6), .DW(16), .BUSY_CYCLES(4096)) dut (
        .rst       (rst),
        .clk       (clk),
        .cs        (cs),
        .sclk      (sclk),
        .sdi       (sdi),
        .sdo       (sdo),
        .dump_addr (dump_addr),
        .dump_din  (dump_din),
        .dump_we   (dump_we),
        .dump_dout (dump_dout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clk_bit(input logic b);
        sdi = b;
        tick(2);
        sclk = 1'b1;
        tick(2);
        sclk = 1'b0;
    endtask

    task automatic cs_on();
        cs = 1'b1;
        tick(1);
    endtask

    task automatic cs_off();
        cs = 1'b0;
        sclk = 1'b0;
        sdi = 1'b0;
        tick(2);
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [5:0] a);
        clk_bit(1'b1);
        for (int i = 1; i >= 0; i--) clk_bit(op[i]);
        for (int i = 5; i >= 0; i--) clk_bit(a[i]);
    endtask

    task automatic send_data(input logic [15:0] d);
        for (int i = 15; i >= 0; i--) clk_bit(d[i]);
    endtask

    task automatic shift_word(output logic [15:0] w);
        w = '0;
        for (int i = 0; i < 16; i++) begin
            clk_bit(1'b0);
            w = {w[14:0], sdo};
        end
    endtask

    // Poll ready with cs high; expiry counts as a failed comparison.
    task automatic wait_ready(input string tag);
        int unsigned n = 0;
        cs_on();
        tick(1);
        while (sdo !== 1'b1 && n < 6000) begin
            tick(1);
            n++;
        end
        if (n >= 6000) chk(tag, {31'd0, sdo}, 32'd1);
        cs_off();
    endtask

    task automatic ewen();
        cs_on(); send_cmd(2'b00, 6'b110000); cs_off();
    endtask

    task automatic ewds();
        cs_on(); send_cmd(2'b00, 6'b000000); cs_off();
    endtask

    task automatic write_word(input logic [5:0] a, input logic [15:0] d);
        cs_on(); send_cmd(2'b01, a); send_data(d); cs_off();
        wait_ready("write_ready");
    endtask

    task automatic read_word(input string tag, input logic [5:0] a, input logic [15:0] exp);
        logic [15:0] w;
        cs_on();
        send_cmd(2'b10, a);
        chk({tag, "_dummy"}, {31'd0, sdo}, 32'd0);
        shift_word(w);
        chk(tag, {16'd0, w}, {16'd0, exp});
        cs_off();
    endtask

    task automatic dump_rd(input string tag, input logic [6:0] a, input logic [7:0] exp);
        dump_addr = a;
        tick(1);
        chk(tag, {24'd0, dump_dout}, {24'd0, exp});
    endtask

    task automatic stream_all(input string tag, input logic [15:0] exp);
        logic [15:0] w;
        cs_on();
        send_cmd(2'b10, 6'd0);
        for (int i = 0; i < 64; i++) begin
            shift_word(w);
            chk(tag, {i[15:0], w}, {i[15:0], exp});
        end
        cs_off();
    endtask

    initial begin
        logic [15:0] w;
        tick(3);
        rst = 1'b0;
        tick(1);

        // reset state
        chk("rst_sdo", {31'd0, sdo}, 32'd1);
        cs_on(); tick(1);
        chk("rst_sdo_cs", {31'd0, sdo}, 32'd1);
        cs_off();

        // 1: enable, write, read back
        ewen();
        write_word(6'd5, 16'hA55A);
        read_word("t1_read5", 6'd5, 16'hA55A);

        // 2: reset clears wen; write is dropped
        rst = 1'b1; tick(2); rst = 1'b0; tick(1);
        write_word(6'd5, 16'h1234);
        read_word("t2_read5", 6'd5, 16'hA55A);
        dump_rd("t2_dump10", 7'd10, 8'h5A);
        dump_rd("t2_dump11", 7'd11, 8'hA5);

        // 3: WRAL then ERAL
        ewen();
        cs_on(); send_cmd(2'b00, 6'b010000); send_data(16'hBEEF); cs_off();
        tick(70);
        wait_ready("wral_ready");
        stream_all("t3_wral", 16'hBEEF);
        dump_rd("t3_dump127", 7'd127, 8'hBE);
        cs_on(); send_cmd(2'b00, 6'b100000); cs_off();
        tick(70);
        wait_ready("eral_ready");
        stream_all("t3_eral", 16'hFFFF);

        // dump write to word 16 low byte
        dump_addr = 7'h20; dump_din = 8'h77; dump_we = 1'b1;
        tick(1);
        dump_we = 1'b0;
        read_word("dump_w16", 6'd16, 16'hFF77);
        dump_rd("dump_rd20", 7'h20, 8'h77);

        // 4: read wraps 63 -> 0
        write_word(6'd63, 16'h1357);
        write_word(6'd0, 16'h2468);
        cs_on();
        send_cmd(2'b10, 6'd63);
        shift_word(w);
        chk("t4_word63", {16'd0, w}, 32'h1357);
        shift_word(w);
        chk("t4_wrap0", {16'd0, w}, 32'h2468);
        cs_off();

        // single-word ERASE
        cs_on(); send_cmd(2'b11, 6'd0); cs_off();
        wait_ready("erase_ready");
        read_word("erase_w0", 6'd0, 16'hFFFF);

        // 5: write aborted after 9 data bits
        write_word(6'd7, 16'h0F0F);
        cs_on(); send_cmd(2'b01, 6'd7);
        for (int i = 0; i < 9; i++) clk_bit(1'b1);
        cs_off();
        read_word("t5_abort", 6'd7, 16'h0F0F);
        ewds();
        write_word(6'd7, 16'hAAAA);
        read_word("t5_ewds", 6'd7, 16'h0F0F);

        // 6: ready/busy after a committed write
        ewen();
        cs_on(); send_cmd(2'b01, 6'd9); send_data(16'h5555); cs_off();
        cs_on(); tick(2);
`ifdef JTPANG_EEPROM_BUSY_EN
        begin
            int unsigned n = 0;
            chk("t6_busy", {31'd0, sdo}, 32'd0);
            while (sdo !== 1'b1 && n < 6000) begin
                tick(1);
                n++;
            end
            chk("t6_busy_len", {31'd0, (n >= 4085 && n <= 4100)}, 32'd1);
        end
`else
        chk("t6_ready", {31'd0, sdo}, 32'd1);
`endif
        cs_off();
        read_word("t6_read9", 6'd9, 16'h5555);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
